instruction_loader: RTL
=======================

// Module: instruction_loader
// PURPOSE
//  Program loader and write-side master for the byte-addressable instruction memory.
//  Accepts a byte stream (valid/ready), packs bytes big-endian into 32-bit words
//  (first byte -> [31:24]) and issues one word write per 4 bytes to the memory write port.
//  Holds the CPU (cpu_hold) until the requested program length has been written.
// PARAMETERS
//  MEM_BYTES   256  instruction memory size in bytes (64 words)
//  ADDR_WIDTH  32   width of mem_write_address, matching the fetch-side address
//  WORD_BYTES  4    bytes per instruction word; fixed, not for override
// PORTS
//  clock              in   1   rising-edge clock
//  reset              in   1   synchronous, active-high
//  start              in   1   pulse: begin load at byte address 0; sampled only in IDLE/DONE
//  word_count         in   7   words to load, latched on start; 0 means 64; values >64 clamp to 64
//  byte_in            in   8   stream byte
//  byte_valid         in   1   byte_in valid
//  byte_ready         out  1   loader accepts a byte this cycle
//  mem_write_en       out  1   one-cycle word write strobe
//  mem_write_address  out  32  byte address of word; always a multiple of 4
//  mem_write_data     out  32  packed word {b0,b1,b2,b3}
//  cpu_hold           out  1   1 = CPU must stall/hold PC
//  load_done          out  1   program fully written
//  checksum_error     out  1   CHECKSUM_EN only; otherwise tied 0
// BEHAVIOUR
//  - Handshake: byte transferred when byte_valid && byte_ready on a clock edge.
//  - Reset values: byte_ready=0, mem_write_en=0, mem_write_address=0, mem_write_data=0,
//    cpu_hold=1, load_done=0, checksum_error=0; state=IDLE; counters 0.
//  - States: IDLE -> (start) COLLECT -> (4th byte accepted) WRITE -> COLLECT | [CHECK] | DONE.
//  - COLLECT: byte_ready=1; byte index 0..3 selects lane [31:24],[23:16],[15:8],[7:0].
//  - WRITE: exactly one cycle, byte_ready=0, mem_write_en=1, address=word_index*4,
//    data=packed word. Latency: 4th byte edge -> write strobe next cycle.
//    Next edge: word_index+1; if equals latched count go to DONE, else COLLECT.
//  - DONE: load_done=1, cpu_hold=0, byte_ready=0; extra stream bytes are not accepted.
//  - start in DONE: restart at address 0, load_done->0, cpu_hold->1 next cycle.
//  - start in COLLECT/WRITE/CHECK: ignored.
//  - Address never exceeds MEM_BYTES-4; no wrap occurs because count is clamped to 64.
//  - Reset mid-load: partial word discarded, no write issued; words already written
//    remain in memory; loader returns to IDLE with cpu_hold=1.
//  - byte_valid low in COLLECT: wait indefinitely, partial word held.
// CONFIGURATION
//  CHECKSUM_EN defined: running XOR of all payload bytes. After the last WRITE, enter
//    CHECK (byte_ready=1), accept one trailer byte, then go to DONE.
//    checksum_error=1 in DONE if trailer != XOR; cleared on start/reset.
//    cpu_hold is still released in DONE; the system decides how to handle the error.
//  CHECKSUM_EN undefined: no CHECK state, no XOR register, checksum_error constant 0.
// STRUCTURE
//  instruction_loader_pkg: state encodings (IDLE, COLLECT, WRITE, CHECK, DONE),
//    MEM_BYTES, WORD_BYTES, MAX_WORDS=64.
//  Sub-module byte_packer: 2-bit lane counter + 32-bit big-endian shift/assemble register;
//    outputs word and word_full. The FSM, address and word counters remain here.
// TESTING
//  1. reset, start, word_count=1, bytes 8'h20,8'h08,8'h00,8'h05 ->
//     one strobe at addr 0, data 32'h20080005; load_done=1 and cpu_hold=0 next cycle.
//  2. word_count=3, bytes 0x00..0x0B -> writes (0,00010203),(4,04050607),(8,08090A0B);
//     exactly 3 strobes.
//  3. word_count=0 -> 64 writes, last at addr 252; byte_ready=0 afterwards; the 257th byte
//     is not accepted.
//  4. Gaps in byte_valid plus reset after 2 bytes of word 1 -> no strobe for the partial word,
//     cpu_hold=1, state IDLE; a subsequent load writes addr 0 correctly.
//  5. start pulsed during COLLECT -> ignored, address sequence unchanged.
//  6. CHECKSUM_EN, count=1, bytes 11,22,33,44, trailer 44 -> checksum_error=0;
//     trailer 45 -> checksum_error=1, load_done=1.

Source files
------------

// File: rtl/instruction_loader_pkg.sv
// Shared definitions for the instruction loader: memory geometry, FSM state
// encoding and the word-count clamp applied when a load is started.
package instruction_loader_pkg;

  localparam int MEM_BYTES  = 256;
  localparam int WORD_BYTES = 4;
  localparam int MAX_WORDS  = MEM_BYTES / WORD_BYTES;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    COLLECT = 3'd1,
    WRITE   = 3'd2,
    CHECK   = 3'd3,
    DONE    = 3'd4
  } state_t;

  // A request of 0 or anything beyond the memory size loads the whole memory.
  function automatic logic [6:0] clamp_count(input logic [6:0] requested);
    logic [6:0] result;
    result = requested;
    if (requested == 7'd0 || requested > 7'(MAX_WORDS)) result = 7'(MAX_WORDS);
    return result;
  endfunction

endpackage

// File: rtl/instruction_loader_packer.sv
// byte_packer: assembles four accepted stream bytes into one big-endian word.
// The first byte of a word lands in [31:23+1], the fourth in [7:0].
// word_full is high in the cycle the fourth byte is being accepted.
module byte_packer (
  input  logic        clock,
  input  logic        reset,
  input  logic        clear,
  input  logic        accept,
  input  logic [7:0]  byte_in,
  output logic [31:0] word,
  output logic        word_full
);

  logic [1:0] lane;

  // Lane counter and lane-addressed byte write into the assembly register.
  always_ff @(posedge clock) begin
    if (reset || clear) begin
      lane <= 2'd0;
      word <= 32'd0;
    end else if (accept) begin
      lane <= lane + 2'd1;
      case (lane)
        2'd0:    word[31:24] <= byte_in;
        2'd1:    word[23:16] <= byte_in;
        2'd2:    word[15:8]  <= byte_in;
        default: word[7:0]   <= byte_in;
      endcase
    end
  end

  assign word_full = accept && (lane == 2'd3);

endmodule

// File: rtl/instruction_loader.sv
// instruction_loader: streams a program into instruction memory, one word
// write per four bytes, and holds the CPU until the requested length is written.
// Optional feature macro: CHECKSUM_EN (XOR trailer byte check after the last word).
//
// Byte handshake: a byte moves when byte_valid && byte_ready are both high at a
// rising clock edge; byte_ready does not depend on byte_valid, and the source may
// hold byte_valid low for any number of cycles without losing the partial word.
module instruction_loader
  import instruction_loader_pkg::*;
#(
  parameter int ADDR_WIDTH = 32
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  start,
  input  logic [6:0]            word_count,
  input  logic [7:0]            byte_in,
  input  logic                  byte_valid,
  output logic                  byte_ready,
  output logic                  mem_write_en,
  output logic [ADDR_WIDTH-1:0] mem_write_address,
  output logic [31:0]           mem_write_data,
  output logic                  cpu_hold,
  output logic                  load_done,
  output logic                  checksum_error,
  output state_t                state
);

  state_t      next_state;
  logic [6:0]  count_q;
  logic [6:0]  word_index;
  logic [31:0] packed_word;
  logic        word_full;
  logic        start_ok;
  logic        accept;
  logic        last_word;

  // start only takes effect when no load is in progress.
  assign start_ok  = start && (state == IDLE || state == DONE);
  assign accept    = byte_valid && byte_ready && (state == COLLECT);
  assign last_word = (word_index + 7'd1) == count_q;

  byte_packer u_packer (
    .clock     (clock),
    .reset     (reset),
    .clear     (start_ok),
    .accept    (accept),
    .byte_in   (byte_in),
    .word      (packed_word),
    .word_full (word_full)
  );

  // State register.
  always_ff @(posedge clock) begin
    if (reset) state <= IDLE;
    else       state <= next_state;
  end

  // Next-state logic.
  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (start) next_state = COLLECT;
      COLLECT: if (word_full) next_state = WRITE;
      WRITE: begin
        if (last_word) begin
`ifdef CHECKSUM_EN
          next_state = CHECK;
`else
          next_state = DONE;
`endif
        end else begin
          next_state = COLLECT;
        end
      end
`ifdef CHECKSUM_EN
      CHECK:   if (byte_valid) next_state = DONE;
`endif
      DONE:    if (start) next_state = COLLECT;
      default: next_state = IDLE;
    endcase
  end

  // Output decode; address and data are driven only during the write strobe.
  always_comb begin
    byte_ready        = 1'b0;
    mem_write_en      = 1'b0;
    mem_write_address = '0;
    mem_write_data    = 32'd0;
    cpu_hold          = 1'b1;
    load_done         = 1'b0;
    case (state)
      COLLECT: byte_ready = 1'b1;
      WRITE: begin
        mem_write_en      = 1'b1;
        mem_write_address = ADDR_WIDTH'({word_index[5:0], 2'b00});
        mem_write_data    = packed_word;
      end
      CHECK:   byte_ready = 1'b1;
      DONE: begin
        cpu_hold  = 1'b0;
        load_done = 1'b1;
      end
      default: ;
    endcase
  end

  // Latched word count and the index of the word currently being written.
  always_ff @(posedge clock) begin
    if (reset) begin
      count_q    <= 7'd0;
      word_index <= 7'd0;
    end else if (start_ok) begin
      count_q    <= clamp_count(word_count);
      word_index <= 7'd0;
    end else if (state == WRITE) begin
      word_index <= word_index + 7'd1;
    end
  end

`ifdef CHECKSUM_EN
  logic [7:0] xor_q;
  logic       error_q;

  // Running XOR of payload bytes, compared against the trailer byte.
  always_ff @(posedge clock) begin
    if (reset || start_ok) begin
      xor_q   <= 8'd0;
      error_q <= 1'b0;
    end else begin
      if (accept) xor_q <= xor_q ^ byte_in;
      if (state == CHECK && byte_valid) error_q <= (byte_in != xor_q);
    end
  end

  assign checksum_error = error_q;
`else
  assign checksum_error = 1'b0;
`endif

endmodule
